// File: rtl/wb_stream_bridge.sv
// wb_stream_bridge
//   Wishbone classic slave that lets the management core feed and drain a
//   val/rdy stream accelerator. CPU writes to TXDATA are queued in a TX FIFO
//   and presented on the tx_* stream; beats arriving on the rx_* stream are
//   queued in an RX FIFO and popped by reading RXDATA. STATUS exposes FIFO
//   levels plus sticky tx_overflow / rx_underflow flags (write-1-to-clear).
//
//   Register map (byte offsets from BASE_ADDR):
//     0x0 TXDATA  write: push (dropped + tx_overflow when full), read: 0
//     0x4 RXDATA  read: pop head (0 + rx_underflow when empty), write: ignored
//     0x8 STATUS  read: levels/flags, write: bit4/bit5 clear the sticky flags
//     0xC reserved, reads 0
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i  Wishbone cycle, strobe, write enable
//   wbs_sel_i             byte selects (ignored, full-word access only)
//   wbs_adr_i/dat_i       byte address, write data
//   wbs_ack_o/dat_o       one-cycle acknowledge, registered read data
//   tx_val/tx_rdy/tx_data output stream towards the accelerator
//   rx_val/rx_rdy/rx_data input stream from the accelerator
module wb_stream_bridge #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          DEPTH     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        tx_val,
   input  logic        tx_rdy,
   output logic [31:0] tx_data,
   input  logic        rx_val,
   output logic        rx_rdy,
   input  logic [31:0] rx_data
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      REG_TXDATA = 2'd0,
      REG_RXDATA = 2'd1,
      REG_STATUS = 2'd2,
      REG_RSVD   = 2'd3
   } reg_sel_e;

   logic [31:0]   tx_mem [DEPTH];
   logic [31:0]   rx_mem [DEPTH];
   logic [AW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
   logic [CW-1:0] tx_count, rx_count;
   logic          tx_overflow, rx_underflow;

   logic          hit, access;
   reg_sel_e      reg_sel;
   logic          tx_full, tx_empty, rx_full, rx_empty;
   logic          tx_push, tx_pop, rx_push, rx_pop;
   logic          tx_ovf_set, tx_ovf_clr, rx_udf_set, rx_udf_clr;
   logic [31:0]   status_word;
   logic [31:0]   read_data;

   // Byte selects and the byte-lane address bits carry no meaning here.
   logic unused_ok;
   assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0]};

   // Gating on !wbs_ack_o yields exactly one ack per access even if the master
   // keeps stb asserted through the ack cycle.
   assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   assign access  = hit & ~wbs_ack_o;
   assign reg_sel = reg_sel_e'(wbs_adr_i[3:2]);

   assign tx_full  = (tx_count == FULL_COUNT);
   assign tx_empty = (tx_count == '0);
   assign rx_full  = (rx_count == FULL_COUNT);
   assign rx_empty = (rx_count == '0);

   assign tx_val  = ~tx_empty;
   assign tx_data = tx_mem[tx_rd_ptr];
   assign rx_rdy  = ~rx_full;

   // Fullness is judged on the pre-edge count, so a push into a full TX FIFO
   // is rejected even when the stream drains an entry in the same cycle.
   assign tx_push    = access & wbs_we_i & (reg_sel == REG_TXDATA) & ~tx_full;
   assign tx_ovf_set = access & wbs_we_i & (reg_sel == REG_TXDATA) & tx_full;
   assign tx_pop     = tx_val & tx_rdy;
   assign rx_push    = rx_val & rx_rdy;
   assign rx_pop     = access & ~wbs_we_i & (reg_sel == REG_RXDATA) & ~rx_empty;
   assign rx_udf_set = access & ~wbs_we_i & (reg_sel == REG_RXDATA) & rx_empty;
   assign tx_ovf_clr = access & wbs_we_i & (reg_sel == REG_STATUS) & wbs_dat_i[4];
   assign rx_udf_clr = access & wbs_we_i & (reg_sel == REG_STATUS) & wbs_dat_i[5];

   assign status_word = {8'd0, 8'(rx_count), 8'(tx_count), 2'b00,
                         rx_underflow, tx_overflow,
                         rx_empty, rx_full, tx_empty, tx_full};

   always_comb begin
      // NOTE: read_data gets a default before the case so no path leaves it
      // unassigned, which would otherwise infer a latch.
      read_data = '0;
      case (reg_sel)
         REG_RXDATA: read_data = rx_empty ? 32'd0 : rx_mem[rx_rd_ptr];
         REG_STATUS: read_data = status_word;
         default:    read_data = '0;
      endcase
   end

   // NOTE: FIFO storage has no reset; the pointers and counts define which
   // entries are valid, so clearing the arrays would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= wbs_dat_i;
      if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
   end

   // NOTE: all state updates use non-blocking assignments so every register
   // sees the pre-edge values of the others, regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         wbs_ack_o    <= 1'b0;
         wbs_dat_o    <= '0;
         tx_wr_ptr    <= '0;
         tx_rd_ptr    <= '0;
         tx_count     <= '0;
         rx_wr_ptr    <= '0;
         rx_rd_ptr    <= '0;
         rx_count     <= '0;
         tx_overflow  <= 1'b0;
         rx_underflow <= 1'b0;
      end else begin
         wbs_ack_o <= access;
         if (access && !wbs_we_i) wbs_dat_o <= read_data;

         if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
         case ({tx_push, tx_pop})
            2'b10:   tx_count <= tx_count + 1'b1;
            2'b01:   tx_count <= tx_count - 1'b1;
            default: tx_count <= tx_count;
         endcase

         if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + 1'b1;
            2'b01:   rx_count <= rx_count - 1'b1;
            default: rx_count <= rx_count;
         endcase

         // A set in the same cycle as a clear wins.
         if (tx_ovf_set)      tx_overflow <= 1'b1;
         else if (tx_ovf_clr) tx_overflow <= 1'b0;
         if (rx_udf_set)      rx_underflow <= 1'b1;
         else if (rx_udf_clr) rx_underflow <= 1'b0;
      end
   end

endmodule
